// File: rtl/fifo_sync_param.sv
`default_nettype none
// ============================================================================
// Module  : fifo_sync_param
// Brief   : Single-clock FIFO with a divided read-slot strobe, registered or
//           first-word-fall-through read, occupancy flags and sticky errors.
// Rev     : 1.0  initial release
// ============================================================================
module fifo_sync_param #(
   parameter int DATA_W   = 32,
   parameter int DEPTH    = 16,
   parameter int AF_LEVEL = DEPTH - 2,
   parameter int AE_LEVEL = 2,
   parameter int RD_DIV   = 6,
   parameter int FWFT     = 0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    wr_en,
   input  logic [DATA_W-1:0]       data_in,
   input  logic                    rd_en,
   input  logic                    clr_err,
   output logic [DATA_W-1:0]       data_out,
   output logic                    rd_valid,
   output logic                    rd_stb,
   output logic                    full,
   output logic                    empty,
   output logic                    almost_full,
   output logic                    almost_empty,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    overflow,
   output logic                    underflow
);

   localparam int              c_AW       = $clog2(DEPTH);
   localparam int              c_CW       = c_AW + 1;
   localparam int              c_DW       = (RD_DIV > 1) ? $clog2(RD_DIV) : 1;
   localparam logic [c_DW-1:0] c_DIV_LAST = c_DW'(RD_DIV - 1);
   localparam logic [c_CW-1:0] c_DEPTH    = c_CW'(DEPTH);
   localparam logic [c_CW-1:0] c_AF       = c_CW'(AF_LEVEL);
   localparam logic [c_CW-1:0] c_AE       = c_CW'(AE_LEVEL);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [c_AW-1:0]   r_wr_ptr;
   logic [c_AW-1:0]   r_rd_ptr;
   logic [c_CW-1:0]   r_count;
   logic [c_DW-1:0]   r_div;
   logic              r_ovf;
   logic              r_unf;

   logic w_stb;
   logic w_full;
   logic w_empty;
   logic w_rd_acc;
   logic w_wr_acc;
   logic w_ovf_evt;
   logic w_unf_evt;

   assign w_stb     = (r_div == c_DIV_LAST);
   assign w_full    = (r_count == c_DEPTH);
   assign w_empty   = (r_count == '0);
   // A pop in the same cycle frees a slot, so a write at full is still legal then.
   assign w_rd_acc  = rd_en & w_stb & ~w_empty;
   assign w_wr_acc  = wr_en & (~w_full | w_rd_acc);
   assign w_ovf_evt = wr_en & w_full & ~w_rd_acc;
   assign w_unf_evt = rd_en & w_stb & w_empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_div    <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_ovf    <= 1'b0;
         r_unf    <= 1'b0;
      end else begin
         r_div <= (r_div == c_DIV_LAST) ? '0 : r_div + c_DW'(1);
         if (w_wr_acc) r_wr_ptr <= r_wr_ptr + c_AW'(1);
         if (w_rd_acc) r_rd_ptr <= r_rd_ptr + c_AW'(1);
         case ({w_wr_acc, w_rd_acc})
            2'b10:   r_count <= r_count + c_CW'(1);
            2'b01:   r_count <= r_count - c_CW'(1);
            default: r_count <= r_count;
         endcase
         // A fresh error outranks a clear arriving in the same cycle.
         r_ovf <= (r_ovf & ~clr_err) | w_ovf_evt;
         r_unf <= (r_unf & ~clr_err) | w_unf_evt;
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr_acc) r_mem[r_wr_ptr] <= data_in;
   end

   generate
      if (FWFT != 0) begin : g_fwft
         assign data_out = w_empty ? '0 : r_mem[r_rd_ptr];
         assign rd_valid = ~w_empty;
      end else begin : g_reg
         logic [DATA_W-1:0] r_dout;
         logic              r_valid;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_dout  <= '0;
               r_valid <= 1'b0;
            end else begin
               r_valid <= w_rd_acc;
               if (w_rd_acc) r_dout <= r_mem[r_rd_ptr];
            end
         end

         assign data_out = r_dout;
         assign rd_valid = r_valid;
      end
   endgenerate

   assign rd_stb       = w_stb;
   assign full         = w_full;
   assign empty        = w_empty;
   assign almost_full  = (r_count >= c_AF);
   assign almost_empty = (r_count <= c_AE);
   assign count        = r_count;
   assign overflow     = r_ovf;
   assign underflow    = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_fifo_sync_param.sv
`default_nettype none
// Bench for fifo_sync_param: vector table, corner sequences and random traffic
// compared against a queue-based model; a second instance covers FWFT mode.
module tb_fifo_sync_param;
   localparam int DEPTH = 16;
   localparam int AF    = 14;
   localparam int AE    = 2;
   localparam int DIV   = 6;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        wr_en = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
   logic [31:0] data_in = '0;
   logic [31:0] data_out;
   logic        rd_valid, rd_stb, full, empty, almost_full, almost_empty, overflow, underflow;
   logic [4:0]  count;

   logic        f_wr = 1'b0, f_rd = 1'b0, f_clr = 1'b0;
   logic [31:0] f_din = '0;
   logic [31:0] f_dout;
   logic        f_valid, f_stb, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
   logic [4:0]  f_count;

   fifo_sync_param u_dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
      .clr_err(clr_err), .data_out(data_out), .rd_valid(rd_valid), .rd_stb(rd_stb),
      .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
      .count(count), .overflow(overflow), .underflow(underflow)
   );

   fifo_sync_param #(.FWFT(1), .RD_DIV(1)) u_fwft (
      .clk(clk), .rst_n(rst_n), .wr_en(f_wr), .data_in(f_din), .rd_en(f_rd),
      .clr_err(f_clr), .data_out(f_dout), .rd_valid(f_valid), .rd_stb(f_stb),
      .full(f_full), .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae),
      .count(f_count), .overflow(f_ovf), .underflow(f_unf)
   );

   // Reference model: contents as a queue, cycle number since reset release.
   logic [31:0] m_q[$];
   logic [31:0] m_dout;
   bit          m_valid, m_ovf, m_unf;
   int          m_cyc;
   int          checks   = 0;
   int          failures = 0;

   typedef struct {
      bit          wr;
      logic [31:0] din;
      bit          rd;
      int          exp_count;
      bit          exp_valid;
      logic [31:0] exp_dout;
   } vec_t;
   vec_t tbl[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_state();
      int sz = m_q.size();
      chk("count", 32'(count), 32'(sz));
      chk("full", 32'(full), 32'(sz == DEPTH));
      chk("empty", 32'(empty), 32'(sz == 0));
      chk("almost_full", 32'(almost_full), 32'(sz >= AF));
      chk("almost_empty", 32'(almost_empty), 32'(sz <= AE));
      chk("data_out", data_out, m_dout);
      chk("rd_valid", 32'(rd_valid), 32'(m_valid));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("underflow", 32'(underflow), 32'(m_unf));
   endtask

   task automatic cycle(input bit wr, input logic [31:0] d, input bit rd, input bit clr);
      bit stb, rd_ok, wr_ok;
      int sz;
      wr_en = wr; data_in = d; rd_en = rd; clr_err = clr;
      sz  = m_q.size();
      stb = ((m_cyc % DIV) == DIV - 1);
      #1;
      chk("rd_stb", 32'(rd_stb), 32'(stb));
      rd_ok = rd && stb && (sz > 0);
      wr_ok = wr && ((sz < DEPTH) || rd_ok);
      m_ovf = (m_ovf && !clr) || (wr && (sz == DEPTH) && !rd_ok);
      m_unf = (m_unf && !clr) || (rd && stb && (sz == 0));
      m_valid = rd_ok;
      if (rd_ok) m_dout = m_q.pop_front();
      if (wr_ok) m_q.push_back(d);
      m_cyc++;
      @(posedge clk);
      #1;
      check_state();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; data_in = '0;
      m_q.delete();
      m_dout = '0; m_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0; m_cyc = 0;
      #1;
      check_state();
      chk("rd_stb_rst", 32'(rd_stb), 32'd0);
      chk("f_rd_stb_rst", 32'(f_stb), 32'd1);
      chk("f_empty_rst", 32'(f_empty), 32'd1);
      chk("f_count_rst", 32'(f_count), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic fcycle(input bit wr, input logic [31:0] d, input bit rd);
      f_wr = wr; f_din = d; f_rd = rd; f_clr = 1'b0;
      @(posedge clk);
      #1;
      f_wr = 1'b0; f_rd = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n, pops;
      // Five writes with rd_en held: one pop per strobe (cycle index 5, 11).
      tbl[0]  = '{1'b1, 32'hA0, 1'b1, 1, 1'b0, 32'h0};
      tbl[1]  = '{1'b1, 32'hA1, 1'b1, 2, 1'b0, 32'h0};
      tbl[2]  = '{1'b1, 32'hA2, 1'b1, 3, 1'b0, 32'h0};
      tbl[3]  = '{1'b1, 32'hA3, 1'b1, 4, 1'b0, 32'h0};
      tbl[4]  = '{1'b1, 32'hA4, 1'b1, 5, 1'b0, 32'h0};
      tbl[5]  = '{1'b0, 32'h0,  1'b1, 4, 1'b1, 32'hA0};
      tbl[6]  = '{1'b0, 32'h0,  1'b1, 4, 1'b0, 32'hA0};
      tbl[7]  = '{1'b0, 32'h0,  1'b1, 4, 1'b0, 32'hA0};
      tbl[8]  = '{1'b0, 32'h0,  1'b1, 4, 1'b0, 32'hA0};
      tbl[9]  = '{1'b0, 32'h0,  1'b1, 4, 1'b0, 32'hA0};
      tbl[10] = '{1'b0, 32'h0,  1'b1, 4, 1'b0, 32'hA0};
      tbl[11] = '{1'b0, 32'h0,  1'b1, 3, 1'b1, 32'hA1};

      repeat (2) @(posedge clk);
      do_reset();
      for (int i = 0; i < 12; i++) begin
         cycle(tbl[i].wr, tbl[i].din, tbl[i].rd, 1'b0);
         chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].exp_count));
         chk($sformatf("tbl%0d_valid", i), 32'(rd_valid), 32'(tbl[i].exp_valid));
         chk($sformatf("tbl%0d_dout", i), data_out, tbl[i].exp_dout);
      end
      repeat (20) cycle(1'b0, '0, 1'b1, 1'b0);

      // Fill, overflow, then drain to confirm the rejected word never landed.
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
         cycle(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0);
         chk("af_fill", 32'(almost_full), 32'((i + 1) >= AF));
      end
      chk("full_16", 32'(full), 32'd1);
      cycle(1'b1, 32'hDEAD, 1'b0, 1'b0);
      chk("ovf_17th", 32'(overflow), 32'd1);
      chk("count_17th", 32'(count), 32'd16);
      repeat (DEPTH * DIV + 6) cycle(1'b0, '0, 1'b1, 1'b0);

      // Write and read together at full; the new word comes out 16th.
      do_reset();
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, 32'h300 + 32'(i), 1'b0, 1'b0);
      while ((m_cyc % DIV) != DIV - 1) cycle(1'b0, '0, 1'b0, 1'b0);
      cycle(1'b1, 32'hBEEF, 1'b1, 1'b0);
      chk("full_rw_count", 32'(count), 32'd16);
      chk("full_rw_ovf", 32'(overflow), 32'd0);
      pops = 0;
      repeat (DEPTH * DIV + 6) begin
         cycle(1'b0, '0, 1'b1, 1'b0);
         if (rd_valid) begin
            pops++;
            if (pops == 16) chk("sixteenth_word", data_out, 32'hBEEF);
         end
      end
      chk("full_rw_pops", 32'(pops), 32'd16);

      // Underflow, clear, clear colliding with a new underflow.
      do_reset();
      repeat (DIV) cycle(1'b0, '0, 1'b1, 1'b0);
      chk("unf_set", 32'(underflow), 32'd1);
      chk("unf_count", 32'(count), 32'd0);
      cycle(1'b0, '0, 1'b0, 1'b1);
      chk("unf_clr", 32'(underflow), 32'd0);
      while ((m_cyc % DIV) != DIV - 1) cycle(1'b0, '0, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b1);
      chk("unf_clr_collide", 32'(underflow), 32'd1);
      cycle(1'b0, '0, 1'b0, 1'b1);
      while ((m_cyc % DIV) != DIV - 1) cycle(1'b0, '0, 1'b0, 1'b0);
      cycle(1'b1, 32'h77, 1'b1, 1'b0);
      chk("wr_rd_empty_count", 32'(count), 32'd1);
      chk("wr_rd_empty_unf", 32'(underflow), 32'd1);

      // Twenty words through a sixteen-entry store: pointers wrap.
      do_reset();
      n = 0;
      while (n < 20) begin
         if (m_q.size() < DEPTH) begin
            cycle(1'b1, 32'h200 + 32'(n), 1'b1, 1'b0);
            n++;
         end else begin
            cycle(1'b0, '0, 1'b1, 1'b0);
         end
      end
      repeat (20 * DIV) cycle(1'b0, '0, 1'b1, 1'b0);
      chk("wrap_empty", 32'(empty), 32'd1);

      // Reset while holding 7 words: nothing stale after release.
      for (int i = 0; i < 7; i++) cycle(1'b1, 32'h400 + 32'(i), 1'b0, 1'b0);
      chk("hold7", 32'(count), 32'd7);
      do_reset();
      pops = 0;
      repeat (2 * DIV) begin
         cycle(1'b0, '0, 1'b1, 1'b0);
         if (rd_valid) pops++;
      end
      chk("no_stale", 32'(pops), 32'd0);

      // Random traffic with occasional resets.
      repeat (600) begin
         if ($urandom_range(0, 199) == 0) do_reset();
         cycle($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 2) != 0,
               $urandom_range(0, 15) == 0);
      end

      // First-word-fall-through instance, strobe every cycle.
      do_reset();
      fcycle(1'b1, 32'h55, 1'b0);
      chk("fwft_dout", f_dout, 32'h55);
      chk("fwft_valid", 32'(f_valid), 32'd1);
      chk("fwft_empty0", 32'(f_empty), 32'd0);
      fcycle(1'b0, '0, 1'b1);
      chk("fwft_empty1", 32'(f_empty), 32'd1);
      chk("fwft_valid0", 32'(f_valid), 32'd0);
      fcycle(1'b1, 32'h11, 1'b0);
      fcycle(1'b1, 32'h22, 1'b0);
      fcycle(1'b1, 32'h33, 1'b0);
      chk("fwft_head", f_dout, 32'h11);
      chk("fwft_count3", 32'(f_count), 32'd3);
      fcycle(1'b0, '0, 1'b1);
      chk("fwft_pop1", f_dout, 32'h22);
      fcycle(1'b0, '0, 1'b1);
      chk("fwft_pop2", f_dout, 32'h33);
      fcycle(1'b0, '0, 1'b1);
      chk("fwft_drained", 32'(f_empty), 32'd1);
      chk("fwft_no_unf", 32'(f_unf), 32'd0);
      fcycle(1'b1, 32'h66, 1'b1);
      chk("fwft_wr_rd_empty_count", 32'(f_count), 32'd1);
      chk("fwft_wr_rd_empty_unf", 32'(f_unf), 32'd1);
      chk("fwft_wr_rd_empty_dout", f_dout, 32'h66);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fifo_sync_param.md
FIFO_SYNC_PARAM -- requirements
Module: fifo_sync_param

Interface
REQ-001 The module SHALL have parameter DATA_W, default 32, meaning data word width in bits.
REQ-002 The module SHALL have parameter DEPTH, default 16, meaning the number of entries (power of two, >=4).
REQ-003 The module SHALL have parameter AF_LEVEL, default DEPTH-2, meaning the almost_full threshold (1..DEPTH).
REQ-004 The module SHALL have parameter AE_LEVEL, default 2, meaning the almost_empty threshold (0..DEPTH-1).
REQ-005 The module SHALL have parameter RD_DIV, default 6, meaning the read-strobe divide ratio (>=1; 1 = every cycle).
REQ-006 The module SHALL have parameter FWFT, default 0, meaning 0 = registered-read mode and 1 = first-word-fall-through mode.
REQ-007 The module SHALL have port clk, input, width 1: the single clock; all logic is rising-edge.
REQ-008 The module SHALL have port rst_n, input, width 1: asynchronous active-low reset.
REQ-009 The module SHALL have port wr_en, input, width 1: write request.
REQ-010 The module SHALL have port data_in, input, width DATA_W: write data.
REQ-011 The module SHALL have port rd_en, input, width 1: read request.
REQ-012 The module SHALL have port clr_err, input, width 1: clear sticky error flags.
REQ-013 The module SHALL have port data_out, output, width DATA_W: read data.
REQ-014 The module SHALL have port rd_valid, output, width 1: data_out is valid.
REQ-015 The module SHALL have port rd_stb, output, width 1: read-slot strobe.
REQ-016 The module SHALL have port full, output, width 1: count == DEPTH.
REQ-017 The module SHALL have port empty, output, width 1: count == 0.
REQ-018 The module SHALL have port almost_full, output, width 1: count >= AF_LEVEL.
REQ-019 The module SHALL have port almost_empty, output, width 1: count <= AE_LEVEL.
REQ-020 The module SHALL have port count, output, width $clog2(DEPTH)+1: current occupancy.
REQ-021 The module SHALL have ports overflow and underflow, output, width 1 each: sticky error flags.

Function
REQ-022 The design SHALL run a divider counter 0..RD_DIV-1 that increments every cycle and wraps; rd_stb SHALL be high exactly when the counter equals RD_DIV-1 (one cycle in RD_DIV).
REQ-023 A read SHALL be accepted iff rd_en && rd_stb && !empty; rd_en outside a strobe cycle SHALL be ignored with no error.
REQ-024 A write SHALL be accepted iff wr_en && (!full || read accepted in the same cycle); an accepted write SHALL store data_in at wr_ptr and advance wr_ptr.
REQ-025 wr_ptr and rd_ptr SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0 without gaps.
REQ-026 count SHALL update on the next edge: +1 on write only, -1 on read only, unchanged on both or neither; it SHALL never exceed DEPTH or go below 0.
REQ-027 Simultaneous write and read on empty SHALL accept the write, reject the read, and set underflow.
REQ-028 full, empty, almost_full and almost_empty SHALL be decoded from the registered count, so they change in the cycle after the causing edge.
REQ-029 FWFT=0: an accepted read SHALL load data_out from mem[rd_ptr] at that edge and pulse rd_valid high for exactly one cycle; data_out SHALL otherwise hold its value.
REQ-030 FWFT=1: data_out SHALL present mem[rd_ptr] whenever !empty, rd_valid SHALL equal !empty, and an accepted read SHALL pop to the next word at that edge.
REQ-031 overflow SHALL set when wr_en && full and no read is accepted that cycle; a rejected write SHALL not modify memory or pointers.
REQ-032 underflow SHALL set when rd_en && rd_stb && empty.
REQ-033 clr_err SHALL clear both flags at the next edge, except that a new error in the same cycle SHALL win and leave its flag set.

Reset
REQ-034 While rst_n=0: pointers, count and divider SHALL be 0; data_out 0; rd_valid 0; full 0; empty 1; almost_empty 1; almost_full 0; overflow and underflow 0; rd_stb 0 (1 if RD_DIV=1).
REQ-035 Asserting reset mid-operation SHALL discard all stored words immediately; memory array contents SHALL not be reset.
REQ-036 After release, the divider SHALL count from 0, so the first rd_stb occurs in the RD_DIV-th cycle after the first rising edge.

Verification
REQ-037 Defaults, FWFT=0: write 0xA0..0xA4 on consecutive cycles, hold rd_en=1 -> count rises to 5; one word per rd_stb (every 6 cycles), in order, each with a 1-cycle rd_valid pulse.
REQ-038 Fill 16 words -> full=1, almost_full asserted at count 14; a 17th write sets overflow, count stays 16, and memory is unchanged on readback.
REQ-039 At full, wr_en and rd_en on an rd_stb cycle -> both accepted, count stays 16, the new word is read out 16th.
REQ-040 On empty, rd_en held over an rd_stb cycle -> underflow=1, count 0; clr_err pulse -> underflow=0; clr_err coinciding with a new underflow -> underflow stays 1.
REQ-041 FWFT=1, RD_DIV=1: write 0x55 -> next cycle data_out=0x55 with rd_valid=1; a read -> empty=1 and rd_valid=0.
REQ-042 Write 20 and read 20 with DEPTH=16 (pointer wrap); assert rst_n=0 holding 7 words -> count 0 and empty 1 immediately, no stale data read after release.
